axil_arbiter_2to1: RTL and testbench

Two-port AXI4-Lite arbiter that shares one AXI4-Lite slave (the 16-register `axi_regfile` behind the PS master port) between two AXI4-Lite masters. Port 0 is the PS M00 port. Port 1 is a fabric-side sequencer. The block grants one complete transaction (read or write) at a time, round-robin between ports, and forwards it to the downstream slave.

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_arbiter_2to1_rr_arb2.sv | 22 ++
 rtl/axil_arbiter_2to1.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_axil_arbiter_2to1.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared types and AXI4-Lite constants for the 2:1 AXI4-Lite
//               arbiter and its benches.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  // Arbiter transaction phases; one complete transaction is in flight at most
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_t;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_arbiter_2to1_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Combinational. When both
//               ports request, the port that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last = 1 means port 1 was served most recently, so port 0 wins a tie
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : axil_arbiter_2to1
// Description : Shares one AXI4-Lite slave between two AXI4-Lite masters.
//               One complete read or write is granted at a time, round-robin
//               between ports, with writes preferred within a port. Channels
//               of the granted port are forwarded combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_arbiter_2to1
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  // Port 0 (PS)
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [2:0]              s0_awprot,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [2:0]              s0_arprot,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  // Port 1 (fabric sequencer)
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [2:0]              s1_awprot,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [2:0]              s1_arprot,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  // Shared downstream slave
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // Status
  output logic [1:0]              grant,
  output logic                    busy
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_sel;
  logic       w_run;

  // Selected-port views of the master-driven signals
  logic [ADDR_WIDTH-1:0]   w_sel_awaddr;
  logic [2:0]              w_sel_awprot;
  logic                    w_sel_awvalid;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [DATA_WIDTH/8-1:0] w_sel_wstrb;
  logic                    w_sel_wvalid;
  logic                    w_sel_bready;
  logic [ADDR_WIDTH-1:0]   w_sel_araddr;
  logic [2:0]              w_sel_arprot;
  logic                    w_sel_arvalid;
  logic                    w_sel_rready;

  // Channel-active qualifiers and downstream handshakes
  logic w_aw_act, w_w_act, w_b_act, w_ar_act, w_r_act;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_req = {s1_awvalid | s1_arvalid, s0_awvalid | s0_arvalid};

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (last_q),
    .gnt  (w_gnt)
  );

  // Everything outward-facing is held quiet while reset is asserted
  assign w_run = ~axi_areset;
  assign w_sel = grant_q[1];

  assign w_sel_awaddr  = w_sel ? s1_awaddr  : s0_awaddr;
  assign w_sel_awprot  = w_sel ? s1_awprot  : s0_awprot;
  assign w_sel_awvalid = w_sel ? s1_awvalid : s0_awvalid;
  assign w_sel_wdata   = w_sel ? s1_wdata   : s0_wdata;
  assign w_sel_wstrb   = w_sel ? s1_wstrb   : s0_wstrb;
  assign w_sel_wvalid  = w_sel ? s1_wvalid  : s0_wvalid;
  assign w_sel_bready  = w_sel ? s1_bready  : s0_bready;
  assign w_sel_araddr  = w_sel ? s1_araddr  : s0_araddr;
  assign w_sel_arprot  = w_sel ? s1_arprot  : s0_arprot;
  assign w_sel_arvalid = w_sel ? s1_arvalid : s0_arvalid;
  assign w_sel_rready  = w_sel ? s1_rready  : s0_rready;

  // A write channel stops forwarding once its handshake has been recorded
  assign w_aw_act = w_run & (state_q == WR_ADDR) & ~aw_done_q;
  assign w_w_act  = w_run & (state_q == WR_ADDR) & ~w_done_q;
  assign w_b_act  = w_run & (state_q == WR_RESP);
  assign w_ar_act = w_run & (state_q == RD_ADDR);
  assign w_r_act  = w_run & (state_q == RD_DATA);

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid  & m_wready;
  assign w_b_hs  = m_bvalid  & m_bready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid  & m_rready;

  // State and bookkeeping registers
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then walk the transaction phases
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q | w_aw_hs;
    w_done_d  = w_done_q  | w_w_hs;
    case (state_q)
      IDLE: begin
        if (|w_gnt) begin
          grant_d = w_gnt;
          last_d  = w_gnt[1];
          // Write takes priority over read within the winning port
          if ((w_gnt[0] & s0_awvalid) | (w_gnt[1] & s1_awvalid)) begin
            state_d = WR_ADDR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if ((aw_done_q | w_aw_hs) & (w_done_q | w_w_hs)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Returning to IDLE releases the grant and clears the write flags
    if (state_d == IDLE) begin
      grant_d   = 2'b00;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // Output logic: forward only the active channel of the granted port
  always_comb begin
    m_awaddr   = '0;
    m_awprot   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_araddr   = '0;
    m_arprot   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_awready = 1'b0;
    s0_wready  = 1'b0;
    s0_bresp   = '0;
    s0_bvalid  = 1'b0;
    s0_arready = 1'b0;
    s0_rdata   = '0;
    s0_rresp   = '0;
    s0_rvalid  = 1'b0;
    s1_awready = 1'b0;
    s1_wready  = 1'b0;
    s1_bresp   = '0;
    s1_bvalid  = 1'b0;
    s1_arready = 1'b0;
    s1_rdata   = '0;
    s1_rresp   = '0;
    s1_rvalid  = 1'b0;
    grant      = w_run ? grant_q : 2'b00;
    busy       = w_run & (state_q != IDLE);

    if (w_aw_act) begin
      m_awvalid  = w_sel_awvalid;
      m_awaddr   = w_sel_awaddr;
      m_awprot   = w_sel_awprot;
      s0_awready = grant_q[0] & m_awready;
      s1_awready = grant_q[1] & m_awready;
    end
    if (w_w_act) begin
      m_wvalid  = w_sel_wvalid;
      m_wdata   = w_sel_wdata;
      m_wstrb   = w_sel_wstrb;
      s0_wready = grant_q[0] & m_wready;
      s1_wready = grant_q[1] & m_wready;
    end
    if (w_b_act) begin
      m_bready = w_sel_bready;
      if (grant_q[0]) begin
        s0_bvalid = m_bvalid;
        s0_bresp  = m_bresp;
      end
      if (grant_q[1]) begin
        s1_bvalid = m_bvalid;
        s1_bresp  = m_bresp;
      end
    end
    if (w_ar_act) begin
      m_arvalid  = w_sel_arvalid;
      m_araddr   = w_sel_araddr;
      m_arprot   = w_sel_arprot;
      s0_arready = grant_q[0] & m_arready;
      s1_arready = grant_q[1] & m_arready;
    end
    if (w_r_act) begin
      m_rready = w_sel_rready;
      if (grant_q[0]) begin
        s0_rvalid = m_rvalid;
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
      end
      if (grant_q[1]) begin
        s1_rvalid = m_rvalid;
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
      end
    end
  end

endmodule : axil_arbiter_2to1
`default_nettype wire

// File: tb/tb_axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_arbiter_2to1
// Description : Directed bench for axil_arbiter_2to1 with a behavioural
//               16-register slave (reg0 = 0xdeadbeef, reg1 = 0x76543210).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter_2to1;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic axi_areset = 1'b1;
  always #5 clk = ~clk;

  // Master-side stimulus, indexed by port
  logic [39:0] s_awaddr [2];
  logic [2:0]  s_awprot [2];
  logic [1:0]  s_awvalid = '0;
  logic [31:0] s_wdata [2];
  logic [3:0]  s_wstrb [2];
  logic [1:0]  s_wvalid = '0;
  logic [1:0]  s_bready = '0;
  logic [39:0] s_araddr [2];
  logic [2:0]  s_arprot [2];
  logic [1:0]  s_arvalid = '0;
  logic [1:0]  s_rready = '0;
  wire  [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  wire  [1:0]  s_bresp0, s_bresp1, s_rresp0, s_rresp1;
  wire  [31:0] s_rdata0, s_rdata1;

  wire  [39:0] m_awaddr, m_araddr;
  wire  [2:0]  m_awprot, m_arprot;
  wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  wire  [31:0] m_wdata;
  wire  [3:0]  m_wstrb;
  wire         m_awready, m_wready, m_arready;
  logic        sv_bvalid, sv_rvalid;
  logic [31:0] sv_rdata;
  wire  [1:0]  grant;
  wire         busy;

  axil_arbiter_2to1 #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_bresp(s_bresp0), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s0_araddr(s_araddr[0]), .s0_arprot(s_arprot[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata0), .s0_rresp(s_rresp0), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_bresp(s_bresp1), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s1_araddr(s_araddr[1]), .s1_arprot(s_arprot[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata1), .s1_rresp(s_rresp1), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(RESP_OKAY), .m_bvalid(sv_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(sv_rdata), .m_rresp(RESP_OKAY), .m_rvalid(sv_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  // Behavioural slave: captures AW/W, commits one cycle later, then responds
  logic [31:0] sregs [16];
  logic        sv_aw_got, sv_w_got;
  logic [3:0]  sv_aw_idx;
  logic [31:0] sv_wdata;
  logic [3:0]  sv_wstrb;
  int          sv_aw_cnt;
  int          aw_wait_cfg = 0;
  int          n_wr = 0;

  assign m_awready = !sv_aw_got && !sv_bvalid && (sv_aw_cnt >= aw_wait_cfg);
  assign m_wready  = !sv_w_got && !sv_bvalid;
  assign m_arready = !sv_rvalid;

  always @(posedge clk) begin
    if (axi_areset) begin
      for (int i = 0; i < 16; i++) sregs[i] <= 32'h0;
      sregs[0]  <= 32'hdeadbeef;
      sregs[1]  <= 32'h76543210;
      sv_aw_got <= 1'b0;
      sv_w_got  <= 1'b0;
      sv_bvalid <= 1'b0;
      sv_rvalid <= 1'b0;
      sv_rdata  <= 32'h0;
      sv_aw_cnt <= 0;
      sv_aw_idx <= 4'h0;
      sv_wdata  <= 32'h0;
      sv_wstrb  <= 4'h0;
    end else begin
      if (m_awvalid && m_awready) begin
        sv_aw_got <= 1'b1;
        sv_aw_idx <= m_awaddr[5:2];
        sv_aw_cnt <= 0;
      end else if (m_awvalid) begin
        sv_aw_cnt <= sv_aw_cnt + 1;
      end
      if (m_wvalid && m_wready) begin
        sv_w_got <= 1'b1;
        sv_wdata <= m_wdata;
        sv_wstrb <= m_wstrb;
      end
      if (sv_aw_got && sv_w_got) begin
        for (int b = 0; b < 4; b++)
          if (sv_wstrb[b]) sregs[sv_aw_idx][8*b +: 8] <= sv_wdata[8*b +: 8];
        sv_aw_got <= 1'b0;
        sv_w_got  <= 1'b0;
        sv_bvalid <= 1'b1;
        n_wr      <= n_wr + 1;
      end
      if (sv_bvalid && m_bready) sv_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        sv_rvalid <= 1'b1;
        sv_rdata  <= sregs[m_araddr[5:2]];
      end
      if (sv_rvalid && m_rready) sv_rvalid <= 1'b0;
    end
  end

  // Observation: grant order, cycle counts and isolation of the idle port
  int         cyc = 0, n_g01 = 0, n_mw = 0, n_maw = 0, n_viol = 0;
  int         b1_last = -1, ar_rise = -1, n_gnt = 0;
  logic       ar_prev = 1'b0;
  logic [1:0] g_prev = 2'b00;
  logic [1:0] gseq [128];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (grant == 2'b01) n_g01 = n_g01 + 1;
    if (m_wvalid) n_mw = n_mw + 1;
    if (m_awvalid) n_maw = n_maw + 1;
    if (s_bvalid[1] && s_bready[1]) b1_last = cyc;
    if (m_arvalid && !ar_prev) ar_rise = cyc;
    ar_prev = m_arvalid;
    if (grant != 2'b00 && g_prev == 2'b00 && n_gnt < 128) begin
      gseq[n_gnt] = grant;
      n_gnt = n_gnt + 1;
    end
    g_prev = grant;
    for (int p = 0; p < 2; p++)
      if (!grant[p] && (s_awready[p] | s_wready[p] | s_bvalid[p] | s_arready[p] | s_rvalid[p]))
        n_viol = n_viol + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int p, input logic [39:0] addr, input logic [31:0] data,
                          input int w_lead, output logic [1:0] resp);
    bit   aw_ok, w_ok, b_ok;
    logic hs_aw, hs_w;
    int   n;
    @(posedge clk); #1;
    s_wdata[p] = data;
    s_wstrb[p] = 4'hf;
    if (w_lead > 0) begin
      s_wvalid[p] = 1'b1;
      repeat (w_lead) @(posedge clk);
      #1;
    end
    s_awaddr[p] = addr;
    s_awprot[p] = 3'b000;
    s_awvalid[p] = 1'b1;
    s_wvalid[p] = 1'b1;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 200) begin
      @(negedge clk);
      hs_aw = s_awvalid[p] & s_awready[p];
      hs_w  = s_wvalid[p] & s_wready[p];
      @(posedge clk); #1;
      if (hs_aw) begin s_awvalid[p] = 1'b0; aw_ok = 1; end
      if (hs_w)  begin s_wvalid[p]  = 1'b0; w_ok  = 1; end
      n++;
    end
    if (!(aw_ok && w_ok)) chk("wr_addr_timeout", {63'd0, aw_ok & w_ok}, 64'd1);
    s_bready[p] = 1'b1;
    b_ok = 0; n = 0; resp = 2'b11;
    while (!b_ok && n < 200) begin
      @(negedge clk);
      if (s_bvalid[p]) begin b_ok = 1; resp = p ? s_bresp1 : s_bresp0; end
      @(posedge clk); #1;
      n++;
    end
    s_bready[p] = 1'b0;
    if (!b_ok) chk("wr_resp_timeout", {63'd0, b_ok}, 64'd1);
  endtask

  task automatic do_read(input int p, input logic [39:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    bit   ok;
    logic hs;
    int   n;
    @(posedge clk); #1;
    s_araddr[p] = addr;
    s_arprot[p] = 3'b000;
    s_arvalid[p] = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      hs = s_arvalid[p] & s_arready[p];
      @(posedge clk); #1;
      if (hs) begin s_arvalid[p] = 1'b0; ok = 1; end
      n++;
    end
    if (!ok) chk("rd_addr_timeout", {63'd0, ok}, 64'd1);
    s_rready[p] = 1'b1;
    ok = 0; n = 0; data = 32'h0; resp = 2'b11;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (s_rvalid[p]) begin
        ok = 1;
        data = p ? s_rdata1 : s_rdata0;
        resp = p ? s_rresp1 : s_rresp0;
      end
      @(posedge clk); #1;
      n++;
    end
    s_rready[p] = 1'b0;
    if (!ok) chk("rd_data_timeout", {63'd0, ok}, 64'd1);
  endtask

  logic [31:0] d0, d1;
  logic [1:0]  r0, r1;
  int          g0, t0, base_g01, base_mw, base_maw, base_wr, base_viol;
  bit          hs_seen;

  initial begin
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_awprot[p] = '0; s_wdata[p] = '0; s_wstrb[p] = '0;
      s_araddr[p] = '0; s_arprot[p] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valids", {59'd0, m_awvalid, m_wvalid, m_arvalid, s_bvalid[0], s_rvalid[0]}, 64'd0);
    @(posedge clk); #1;
    axi_areset = 1'b0;

    // Simultaneous reads of 0x00: port 0 first, port 1 held off meanwhile
    g0 = n_gnt; base_viol = n_viol;
    fork
      do_read(0, 40'h00, d0, r0);
      do_read(1, 40'h00, d1, r1);
    join
    chk("simrd_p0_data", {32'd0, d0}, 64'hdeadbeef);
    chk("simrd_p1_data", {32'd0, d1}, 64'hdeadbeef);
    chk("simrd_first_grant", {62'd0, gseq[g0]}, 64'd1);
    chk("simrd_second_grant", {62'd0, gseq[g0+1]}, 64'd2);
    chk("simrd_isolation", n_viol - base_viol, 64'd0);

    // Continuous contention for 8 transactions: strict alternation
    g0 = n_gnt;
    fork
      begin repeat (4) do_read(0, 40'h04, d0, r0); end
      begin repeat (4) do_read(1, 40'h00, d1, r1); end
    join
    chk("rr_count", n_gnt - g0, 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_grant_%0d", k), {62'd0, gseq[g0+k]}, (k % 2 == 0) ? 64'd1 : 64'd2);

    // Single write from port 0, then read it back
    base_g01 = n_g01;
    do_write(0, 40'h08, 32'h3, 0, r0);
    chk("wr_bresp", {62'd0, r0}, {62'd0, RESP_OKAY});
    chk("wr_grant_cycles", n_g01 - base_g01, 64'd3);
    do_read(0, 40'h08, d0, r0);
    chk("wr_readback", {32'd0, d0}, 64'h3);

    // W leads AW by 3 cycles, slave stalls awready for 2 cycles
    aw_wait_cfg = 2;
    base_mw = n_mw; base_maw = n_maw; base_wr = n_wr;
    do_write(0, 40'h0C, 32'ha5a50001, 3, r0);
    aw_wait_cfg = 0;
    chk("wlead_mwvalid_cycles", n_mw - base_mw, 64'd1);
    chk("wlead_mawvalid_cycles", n_maw - base_maw, 64'd3);
    chk("wlead_slave_writes", n_wr - base_wr, 64'd1);
    do_read(1, 40'h0C, d1, r1);
    chk("wlead_readback", {32'd0, d1}, 64'ha5a50001);

    // Port 1 write and read together: write first, B before AR
    t0 = cyc;
    fork
      do_write(1, 40'h10, 32'h55, 0, r1);
      do_read(1, 40'h10, d1, r0);
    join
    chk("p1_bresp", {62'd0, r1}, {62'd0, RESP_OKAY});
    chk("p1_b_before_ar", {63'd0, (b1_last > t0) && (b1_last < ar_rise)}, 64'd1);
    chk("p1_read_sees_write", {32'd0, d1}, 64'h55);

    // Reset pulsed while port 0 read sits in the data phase
    s_araddr[0] = 40'h04;
    s_arvalid[0] = 1'b1;
    hs_seen = 0;
    for (int n = 0; n < 50 && !hs_seen; n++) begin
      @(negedge clk);
      hs_seen = s_arready[0];
      @(posedge clk); #1;
    end
    s_arvalid[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_rvalid", {62'd0, s_rvalid[0], busy}, 64'd3);
    @(posedge clk); #1;
    axi_areset = 1'b1;
    @(negedge clk);
    chk("rstmid_during", {56'd0, grant, busy, m_arvalid, m_rready, s_rvalid[0], s_arready[0], m_awvalid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_after_edge", {57'd0, grant, busy, s_rvalid[0], s_bvalid[0], m_wvalid}, 64'd0);
    @(posedge clk); #1;
    axi_areset = 1'b0;
    do_read(0, 40'h04, d0, r0);
    chk("rstmid_read", {32'd0, d0}, 64'h76543210);
    chk("rstmid_rresp", {62'd0, r0}, {62'd0, RESP_OKAY});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_axil_arbiter_2to1
`default_nettype wire
